// File: rtl/cache_arbiter_pkg.sv
// Shared types for the cache-to-memory arbiter: RV32I word type, FSM states,
// grant encoding and the line-alignment helper.
package rv32i_types;
  typedef logic [31:0] rv32i_word;
endpackage

package arbiter_types;
  import rv32i_types::*;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    I_READ  = 3'd1,
    D_READ  = 3'd2,
    D_WRITE = 3'd3,
    DONE    = 3'd4
  } arb_state_t;

  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } grant_t;

  localparam int OFFSET_BITS = 5;

  function automatic rv32i_word line_align(input rv32i_word addr);
    return {addr[31:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
  endfunction
endpackage

// File: rtl/cache_arbiter_if.sv
// Bundle of I-cache, D-cache and physical-memory signals seen by the arbiter.
interface cache_arbiter_if #(
  parameter int LINE_WIDTH = 256,
  parameter int BEAT_WIDTH = 64
);
  import rv32i_types::*;

  logic                  i_pmem_read;
  rv32i_word             i_pmem_address;
  logic [LINE_WIDTH-1:0] i_pmem_rdata;
  logic                  i_pmem_resp;

  logic                  d_pmem_read;
  logic                  d_pmem_write;
  rv32i_word             d_pmem_address;
  logic [LINE_WIDTH-1:0] d_pmem_wdata;
  logic [LINE_WIDTH-1:0] d_pmem_rdata;
  logic                  d_pmem_resp;

  logic                  mem_read;
  logic                  mem_write;
  rv32i_word             mem_address;
  logic [BEAT_WIDTH-1:0] mem_wdata;
  logic [BEAT_WIDTH-1:0] mem_rdata;
  logic                  mem_resp;

  modport slave (
    input  i_pmem_read, i_pmem_address,
    output i_pmem_rdata, i_pmem_resp,
    input  d_pmem_read, d_pmem_write, d_pmem_address, d_pmem_wdata,
    output d_pmem_rdata, d_pmem_resp,
    output mem_read, mem_write, mem_address, mem_wdata,
    input  mem_rdata, mem_resp
  );

  modport master (
    output i_pmem_read, i_pmem_address,
    input  i_pmem_rdata, i_pmem_resp,
    output d_pmem_read, d_pmem_write, d_pmem_address, d_pmem_wdata,
    input  d_pmem_rdata, d_pmem_resp,
    input  mem_read, mem_write, mem_address, mem_wdata,
    output mem_rdata, mem_resp
  );
endinterface

// File: rtl/cache_arbiter_burst_buffer.sv
// Beat counter and line buffer: assembles read beats into a line and slices
// the writeback line into beats.
module burst_buffer #(
  parameter int LINE_WIDTH = 256,
  parameter int BEAT_WIDTH = 64,
  parameter int BEATS      = LINE_WIDTH / BEAT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_clear,
  input  logic                  i_beat_ack,
  input  logic                  i_capture,
  input  logic [BEAT_WIDTH-1:0] i_rdata,
  input  logic [LINE_WIDTH-1:0] i_wline,
  output logic [BEAT_WIDTH-1:0] o_wbeat,
  output logic [LINE_WIDTH-1:0] o_line,
  output logic                  o_last_beat
);
  localparam int CW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

  logic [CW-1:0]         r_count;
  logic [LINE_WIDTH-1:0] r_line;

  // Counter wraps to zero naturally after the last beat.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
      r_line  <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_beat_ack) begin
      if (i_capture) begin
        r_line[r_count*BEAT_WIDTH +: BEAT_WIDTH] <= i_rdata;
      end
      r_count <= r_count + CW'(1);
    end
  end

  assign o_wbeat     = i_wline[r_count*BEAT_WIDTH +: BEAT_WIDTH];
  assign o_line      = r_line;
  assign o_last_beat = (r_count == LAST);
endmodule

// File: rtl/cache_arbiter.sv
// Round-robin arbiter sharing one burst memory port between I-cache and D-cache.
module cache_arbiter
  import rv32i_types::*;
  import arbiter_types::*;
#(
  parameter int LINE_WIDTH = 256,
  parameter int BEAT_WIDTH = 64,
  parameter int BEATS      = LINE_WIDTH / BEAT_WIDTH
) (
  input logic            clk,
  input logic            rst,
  cache_arbiter_if.slave bus
);
  arb_state_t r_state, w_next_state;
  grant_t     r_target, r_last_grant;
  rv32i_word  r_addr, w_req_addr;
  logic       r_mem_read, r_mem_write, r_i_resp, r_d_resp;
  logic       w_i_req, w_d_req, w_in_burst, w_last_beat, w_grant;
  logic [BEAT_WIDTH-1:0] w_wbeat;
  logic [LINE_WIDTH-1:0] w_line;

  assign w_i_req    = bus.i_pmem_read;
  assign w_d_req    = bus.d_pmem_read | bus.d_pmem_write;
  assign w_in_burst = (r_state == I_READ) || (r_state == D_READ) || (r_state == D_WRITE);

  // Next-state and grant decision; ties go to the side not granted last.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (w_d_req && (!w_i_req || (r_last_grant == GRANT_I))) begin
          w_next_state = bus.d_pmem_write ? D_WRITE : D_READ;
        end else if (w_i_req) begin
          w_next_state = I_READ;
        end else begin
          w_next_state = IDLE;
        end
      end
      I_READ, D_READ, D_WRITE: begin
        if (bus.mem_resp && w_last_beat) begin
          w_next_state = DONE;
        end else begin
          w_next_state = r_state;
        end
      end
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  assign w_grant    = (r_state == IDLE) && (w_next_state != IDLE);
  assign w_req_addr = (w_next_state == I_READ) ? bus.i_pmem_address : bus.d_pmem_address;

  // State, grant bookkeeping and registered memory/response strobes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_target     <= GRANT_I;
      r_last_grant <= GRANT_I;
      r_addr       <= '0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_i_resp     <= 1'b0;
      r_d_resp     <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_mem_read  <= (w_next_state == I_READ) || (w_next_state == D_READ);
      r_mem_write <= (w_next_state == D_WRITE);
      r_i_resp    <= (w_next_state == DONE) && (r_target == GRANT_I);
      r_d_resp    <= (w_next_state == DONE) && (r_target == GRANT_D);
      if (w_grant) begin
        r_addr       <= line_align(w_req_addr);
        r_target     <= (w_next_state == I_READ) ? GRANT_I : GRANT_D;
        r_last_grant <= (w_next_state == I_READ) ? GRANT_I : GRANT_D;
      end
    end
  end

  burst_buffer #(
    .LINE_WIDTH(LINE_WIDTH),
    .BEAT_WIDTH(BEAT_WIDTH),
    .BEATS     (BEATS)
  ) u_buf (
    .clk        (clk),
    .rst        (rst),
    .i_clear    (r_state == IDLE),
    .i_beat_ack (bus.mem_resp && w_in_burst),
    .i_capture  ((r_state == I_READ) || (r_state == D_READ)),
    .i_rdata    (bus.mem_rdata),
    .i_wline    (bus.d_pmem_wdata),
    .o_wbeat    (w_wbeat),
    .o_line     (w_line),
    .o_last_beat(w_last_beat)
  );

  assign bus.mem_read     = r_mem_read;
  assign bus.mem_write    = r_mem_write;
  assign bus.mem_address  = r_addr;
  assign bus.mem_wdata    = r_mem_write ? w_wbeat : '0;
  assign bus.i_pmem_resp  = r_i_resp;
  assign bus.d_pmem_resp  = r_d_resp;
  assign bus.i_pmem_rdata = w_line;
  assign bus.d_pmem_rdata = w_line;
endmodule

// File: tb/tb_cache_arbiter.sv
// Directed self-checking bench for cache_arbiter; cycle 0 is the cycle a request is raised.
module tb_cache_arbiter;
  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  cache_arbiter_if #(.LINE_WIDTH(256), .BEAT_WIDTH(64)) bus ();

  cache_arbiter #(.LINE_WIDTH(256), .BEAT_WIDTH(64), .BEATS(4)) dut (
    .clk(clk),
    .rst(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_mem_read"}, 256'(bus.mem_read), 256'(0));
    chk({tag, "_mem_write"}, 256'(bus.mem_write), 256'(0));
    chk({tag, "_mem_address"}, 256'(bus.mem_address), 256'(0));
    chk({tag, "_mem_wdata"}, 256'(bus.mem_wdata), 256'(0));
    chk({tag, "_i_resp"}, 256'(bus.i_pmem_resp), 256'(0));
    chk({tag, "_d_resp"}, 256'(bus.d_pmem_resp), 256'(0));
    chk({tag, "_i_rdata"}, bus.i_pmem_rdata, 256'(0));
    chk({tag, "_d_rdata"}, bus.d_pmem_rdata, 256'(0));
  endtask

  // Entered at the negedge of the first burst cycle; memory acks every cycle.
  // Returns at the negedge of the response cycle.
  task automatic read_burst(input string tag, input logic [31:0] addr, input logic to_d,
                            input logic [255:0] line);
    chk({tag, "_mem_read"}, 256'(bus.mem_read), 256'(1));
    chk({tag, "_mem_write"}, 256'(bus.mem_write), 256'(0));
    chk({tag, "_mem_address"}, 256'(bus.mem_address), 256'(addr));
    for (int b = 0; b < 4; b++) begin
      chk({tag, "_resp_early"}, 256'({bus.i_pmem_resp, bus.d_pmem_resp}), 256'(0));
      bus.mem_resp  = 1'b1;
      bus.mem_rdata = line[b*64 +: 64];
      @(negedge clk);
    end
    bus.mem_resp = 1'b0;
    chk({tag, "_mem_read_done"}, 256'(bus.mem_read), 256'(0));
    chk({tag, "_i_resp"}, 256'(bus.i_pmem_resp), 256'(!to_d));
    chk({tag, "_d_resp"}, 256'(bus.d_pmem_resp), 256'(to_d));
    chk({tag, "_rdata"}, to_d ? bus.d_pmem_rdata : bus.i_pmem_rdata, line);
  endtask

  // Write burst with memory acks following pattern bit c for cycle c (1..n).
  task automatic write_burst(input string tag, input logic [31:0] addr, input logic [255:0] line,
                             input logic [10:1] pat, input int n);
    int idx;
    idx = 0;
    chk({tag, "_mem_address"}, 256'(bus.mem_address), 256'(addr));
    for (int c = 1; c <= n; c++) begin
      chk({tag, "_mem_write"}, 256'(bus.mem_write), 256'(1));
      chk({tag, "_mem_read"}, 256'(bus.mem_read), 256'(0));
      chk({tag, "_wdata"}, 256'(bus.mem_wdata), 256'(line[idx*64 +: 64]));
      chk({tag, "_d_resp_early"}, 256'(bus.d_pmem_resp), 256'(0));
      bus.mem_resp = pat[c];
      @(negedge clk);
      if (pat[c]) idx++;
    end
    bus.mem_resp = 1'b0;
    chk({tag, "_mem_write_done"}, 256'(bus.mem_write), 256'(0));
    chk({tag, "_d_resp"}, 256'(bus.d_pmem_resp), 256'(1));
    chk({tag, "_i_resp"}, 256'(bus.i_pmem_resp), 256'(0));
  endtask

  initial begin
    logic [255:0] line_a, line_b, line_c, line_w, line_x;
    checks   = 0;
    failures = 0;
    clk      = 1'b0;
    rst_n    = 1'b0;
    bus.i_pmem_read    = 1'b0;
    bus.i_pmem_address = 32'h0;
    bus.d_pmem_read    = 1'b0;
    bus.d_pmem_write   = 1'b0;
    bus.d_pmem_address = 32'h0;
    bus.d_pmem_wdata   = 256'h0;
    bus.mem_rdata      = 64'h0;
    bus.mem_resp       = 1'b0;
    line_a = {64'h4444444444444444, 64'h3333333333333333, 64'h2222222222222222, 64'h1111111111111111};
    line_b = {64'hB3B3B3B3B3B3B3B3, 64'hB2B2B2B2B2B2B2B2, 64'hB1B1B1B1B1B1B1B1, 64'hB0B0B0B0B0B0B0B0};
    line_c = {64'hC3C3C3C3C3C3C3C3, 64'hC2C2C2C2C2C2C2C2, 64'hC1C1C1C1C1C1C1C1, 64'hC0C0C0C0C0C0C0C0};
    line_w = {64'hDDDDDDDDDDDDDDDD, 64'hCCCCCCCCCCCCCCCC, 64'hBBBBBBBBBBBBBBBB, 64'hAAAAAAAAAAAAAAAA};
    line_x = {64'h0123456789ABCDEF, 64'hFEDCBA9876543210, 64'h5555AAAA5555AAAA, 64'h0F0F0F0F0F0F0F0F};

    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Tie out of reset: D first, one idle cycle, then I; later ties alternate.
    bus.i_pmem_read = 1'b1;  bus.i_pmem_address = 32'h0000_0104;
    bus.d_pmem_read = 1'b1;  bus.d_pmem_address = 32'h0000_2010;
    chk("tie_no_comb_path", 256'(bus.mem_read), 256'(0));
    @(negedge clk);
    read_burst("tie1_d", 32'h0000_2000, 1'b1, line_b);
    bus.d_pmem_read = 1'b0;
    @(negedge clk);
    chk("tie_bubble", 256'(bus.mem_read), 256'(0));
    chk("tie_d_single", 256'(bus.d_pmem_resp), 256'(0));
    @(negedge clk);
    read_burst("tie2_i", 32'h0000_0100, 1'b0, line_c);
    bus.d_pmem_read = 1'b1;  bus.d_pmem_address = 32'h0000_3000;
    @(negedge clk);
    chk("tie_bubble2", 256'(bus.mem_read), 256'(0));
    @(negedge clk);
    read_burst("tie3_d", 32'h0000_3000, 1'b1, line_a);
    @(negedge clk);
    chk("tie_bubble3", 256'(bus.mem_read), 256'(0));
    @(negedge clk);
    read_burst("tie4_i", 32'h0000_0100, 1'b0, line_b);
    bus.i_pmem_read = 1'b0;
    bus.d_pmem_read = 1'b0;
    @(negedge clk);

    // Lone I-read with address alignment.
    bus.i_pmem_read = 1'b1;  bus.i_pmem_address = 32'h0000_1234;
    @(negedge clk);
    bus.i_pmem_address = 32'h0000_9999;
    read_burst("iread", 32'h0000_1220, 1'b0, line_a);
    bus.i_pmem_read = 1'b0;
    @(negedge clk);
    chk("iread_single_pulse", 256'(bus.i_pmem_resp), 256'(0));

    // D-write with gapped memory acks at cycles 3, 6, 7, 10.
    bus.d_pmem_write = 1'b1;  bus.d_pmem_address = 32'h0000_8047;  bus.d_pmem_wdata = line_w;
    @(negedge clk);
    write_burst("dwrite", 32'h0000_8040, line_w, 10'b1001100100, 10);
    bus.d_pmem_write = 1'b0;
    @(negedge clk);
    chk("dwrite_single_pulse", 256'(bus.d_pmem_resp), 256'(0));

    // Read and write together: write takes precedence.
    bus.d_pmem_read = 1'b1;  bus.d_pmem_write = 1'b1;
    bus.d_pmem_address = 32'h0000_0040;  bus.d_pmem_wdata = line_x;
    @(negedge clk);
    write_burst("rw", 32'h0000_0040, line_x, 10'b0000001111, 4);
    bus.d_pmem_read = 1'b0;  bus.d_pmem_write = 1'b0;
    @(negedge clk);

    // Spurious acks in IDLE must not disturb the counter or produce a response.
    bus.mem_resp = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("spurious_mem_read", 256'(bus.mem_read), 256'(0));
      chk("spurious_resp", 256'({bus.i_pmem_resp, bus.d_pmem_resp}), 256'(0));
    end
    bus.mem_resp = 1'b0;
    bus.d_pmem_read = 1'b1;  bus.d_pmem_address = 32'h0000_0080;
    @(negedge clk);
    read_burst("after_spurious", 32'h0000_0080, 1'b1, line_c);
    bus.d_pmem_read = 1'b0;
    @(negedge clk);

    // Reset pulsed during beat 2 of an I-read, then a fresh request.
    bus.i_pmem_read = 1'b1;  bus.i_pmem_address = 32'h0000_0500;
    @(negedge clk);
    chk("midrst_mem_read", 256'(bus.mem_read), 256'(1));
    bus.mem_resp = 1'b1;  bus.mem_rdata = 64'h9999999999999999;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_all_zero("midrst");
    bus.mem_resp = 1'b0;
    @(negedge clk);
    chk("midrst_no_resp", 256'({bus.i_pmem_resp, bus.d_pmem_resp}), 256'(0));
    rst_n = 1'b1;
    bus.i_pmem_address = 32'h0000_0600;
    @(negedge clk);
    read_burst("after_rst", 32'h0000_0600, 1'b0, line_x);
    bus.i_pmem_read = 1'b0;
    @(negedge clk);
    chk("after_rst_single", 256'(bus.i_pmem_resp), 256'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cache_arbiter.md
# cache_arbiter

Shares the single burst-oriented physical memory port between the instruction cache (IF stage) and the data cache (MEM stage) of the pipelined RV32IM core. It accepts one 256-bit line request at a time from either cache and converts it into a four-beat, 64-bit memory burst. It assembles or slices the line and returns a one-cycle response to the granted cache. Ties between the two caches are broken round-robin, so neither stage starves.

## Interface
Parameters:
- LINE_WIDTH, 256, cache line width in bits.
- BEAT_WIDTH, 64, memory bus width in bits.
- BEATS, LINE_WIDTH/BEAT_WIDTH (4), beats per burst; must be a power of two.

Ports:
- clk  in  1  sole clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- i_pmem_read  in  1  I-cache line read request; held until i_pmem_resp.
- i_pmem_address  in  32  I-cache line address (rv32i_word).
- i_pmem_rdata  out  LINE_WIDTH  line returned to I-cache; valid only while i_pmem_resp.
- i_pmem_resp  out  1  one-cycle completion pulse to I-cache.
- d_pmem_read  in  1  D-cache line read request; held until d_pmem_resp.
- d_pmem_write  in  1  D-cache line writeback request; held until d_pmem_resp.
- d_pmem_address  in  32  D-cache line address.
- d_pmem_wdata  in  LINE_WIDTH  writeback line; held stable until d_pmem_resp.
- d_pmem_rdata  out  LINE_WIDTH  line returned to D-cache; valid only while d_pmem_resp.
- d_pmem_resp  out  1  one-cycle completion pulse to D-cache.
- mem_read  out  1  burst read to physical memory.
- mem_write  out  1  burst write to physical memory.
- mem_address  out  32  line-aligned burst address; bits [4:0] are always 0.
- mem_wdata  out  BEAT_WIDTH  current write beat.
- mem_rdata  in  BEAT_WIDTH  current read beat; valid when mem_resp is high.
- mem_resp  in  1  per-beat acknowledge from memory.

## Operation
- FSM states:
  - IDLE: no outputs asserted except buffered data; sample the requests.
  - I_READ and D_READ: mem_read is high.
  - D_WRITE: mem_write is high.
  - DONE: resp pulse to the granted cache.
- Arbitration in IDLE:
  - D request only: go to D_READ or D_WRITE. d_pmem_write has precedence if both d_pmem_read and d_pmem_write are high.
  - I request only: go to I_READ.
  - Both pending: grant the side opposite to last_grant.
  - last_grant updates on every grant and resets to I, so D wins the first tie.
- On grant, latch the address with bits [4:0] zeroed into addr_q, and latch the target.
- The beat counter (log2 BEATS bits) starts at 0 and increments on each mem_resp.
- Read beat n: mem_rdata is written to line_q[n*BEAT_WIDTH +: BEAT_WIDTH]. Beat 0 is the lowest-addressed 8 bytes.
- Write beat n: mem_wdata = d_pmem_wdata[n*BEAT_WIDTH +: BEAT_WIDTH], driven combinationally from the counter.
- mem_resp while the counter equals BEATS-1: the counter wraps to 0 and the FSM goes to DONE. mem_read and mem_write are low from DONE onward.
- DONE: assert the resp of the granted side for exactly one cycle, then return to IDLE.
  - i_pmem_rdata and d_pmem_rdata both drive line_q.
  - The resp of the non-granted side stays 0.
- mem_resp seen in IDLE or DONE is ignored.
- The arbiter never preempts a burst in flight.

## Timing
- Reset (rst low, asynchronous):
  - State is IDLE, counter 0, last_grant I, addr_q 0, line_q 0.
  - All outputs are 0: mem_read, mem_write, mem_address, mem_wdata, both resp, both rdata.
- Request high in IDLE at cycle 0 gives mem_read or mem_write high at cycle 1. Outputs come from registered state, with no combinational request-to-memory path.
- If the beats are acknowledged at cycles k..k+3, resp is high at cycle k+4. Minimum request-to-resp is 5 cycles (k=1).
- The requester drops its request in the cycle after resp. The arbiter is back in IDLE that cycle and accepts a new request, with a 1-cycle bubble minimum.
- Reset asserted mid-burst: abort immediately to reset values. No resp is issued, and the memory model sees mem_read or mem_write drop.
- A request that changes its address while pending is sampled only in IDLE; later changes are ignored.

## Structure
- Package arbiter_types holds:
  - enum arb_state_t {IDLE, I_READ, D_READ, D_WRITE, DONE}
  - enum grant_t {GRANT_I, GRANT_D}
  - localparam OFFSET_BITS = 5
- Addresses use rv32i_word from rv32i_types.
- Natural sub-module: burst_buffer. It holds the beat counter and line_q, and provides:
  - clear
  - beat capture
  - write-slice select
  - last_beat flag
- The FSM and arbitration stay in cache_arbiter.

## Test plan
- I-read alone: i_pmem_read at address 0x0000_1234, memory returns beats 0x11..,0x22..,0x33..,0x44.. with resp every cycle.
  - mem_address must be 0x0000_1220.
  - i_pmem_rdata = {0x44..,0x33..,0x22..,0x11..}.
  - i_pmem_resp is a single pulse at cycle 5; d_pmem_resp stays 0.
- D-write with a gapped memory: wdata beats A,B,C,D, mem_resp on cycles 3, 6, 7, 10.
  - mem_wdata advances only after each resp.
  - d_pmem_resp is a single pulse at cycle 11.
- Simultaneous I-read and D-read out of reset:
  - D is served first, then I, with a 1-cycle IDLE between the bursts.
  - Repeat the tie: the grants alternate.
- d_pmem_read and d_pmem_write both high: a write burst is issued and mem_read stays 0.
- Reset pulsed low during beat 2 of an I_READ:
  - All outputs are 0 immediately and no resp fires.
  - A fresh request afterwards completes with correct data.
- Spurious mem_resp while IDLE: no state change and no resp output.
